// File: rtl/cache_controller_if.sv
// Control/status bundle between the cache controller FSM and the cache datapath.
// The controller drives the ten strobes; the datapath returns three status bits.
interface cache_internal_if;
   logic miss_recovery_mode;
   logic set_hmem_block_address;
   logic reset_counter;
   logic use_victim_tag_for_hmem_block_address;
   logic decrement_counter;
   logic clear_selected_dirty_bit;
   logic clear_selected_valid_bit;
   logic finish_new_line_install;
   logic perform_write;
   logic set_selected_dirty_bit;
   logic valid_block_match;
   logic valid_dirty_bit;
   logic counter_done;

   modport controller (
      output miss_recovery_mode, set_hmem_block_address, reset_counter,
             use_victim_tag_for_hmem_block_address, decrement_counter,
             clear_selected_dirty_bit, clear_selected_valid_bit,
             finish_new_line_install, perform_write, set_selected_dirty_bit,
      input  valid_block_match, valid_dirty_bit, counter_done
   );

   modport datapath (
      input  miss_recovery_mode, set_hmem_block_address, reset_counter,
             use_victim_tag_for_hmem_block_address, decrement_counter,
             clear_selected_dirty_bit, clear_selected_valid_bit,
             finish_new_line_install, perform_write, set_selected_dirty_bit,
      output valid_block_match, valid_dirty_bit, counter_done
   );

   modport master (
      output miss_recovery_mode, set_hmem_block_address, reset_counter,
             use_victim_tag_for_hmem_block_address, decrement_counter,
             clear_selected_dirty_bit, clear_selected_valid_bit,
             finish_new_line_install, perform_write, set_selected_dirty_bit,
      input  valid_block_match, valid_dirty_bit, counter_done
   );

   modport slave (
      input  miss_recovery_mode, set_hmem_block_address, reset_counter,
             use_victim_tag_for_hmem_block_address, decrement_counter,
             clear_selected_dirty_bit, clear_selected_valid_bit,
             finish_new_line_install, perform_write, set_selected_dirty_bit,
      output valid_block_match, valid_dirty_bit, counter_done
   );
endinterface

// File: rtl/cache_controller.sv
// Cache sequencing FSM: hit/miss resolution, dirty write-back, line fill, replayed lookup.
// Optional statistics counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_controller #(
   parameter int STAT_WIDTH = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic req_valid,
   input  logic req_op,
   output logic req_ready,
   output logic resp_valid,
   output logic hmem_req,
   output logic hmem_we,
   input  logic hmem_ack,
   cache_internal_if.controller ctrl
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] hit_count,
   output logic [STAT_WIDTH-1:0] miss_count,
   output logic [STAT_WIDTH-1:0] writeback_count
`endif
);

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} state_t;

   state_t state_reg;
   state_t state_next;
   logic   op_reg;

   generate
      if (STAT_WIDTH < 1) begin : g_bad_stat_width
         $error("STAT_WIDTH must be at least 1");
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && req_valid) begin
            op_reg <= req_op;
         end
      end
   end

   // Outputs are forced to their idle values while reset is high so hmem_req drops at once.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      hmem_req   = 1'b0;
      hmem_we    = 1'b0;
      ctrl.miss_recovery_mode                    = 1'b0;
      ctrl.set_hmem_block_address                = 1'b0;
      ctrl.reset_counter                         = 1'b0;
      ctrl.use_victim_tag_for_hmem_block_address = 1'b0;
      ctrl.decrement_counter                     = 1'b0;
      ctrl.clear_selected_dirty_bit              = 1'b0;
      ctrl.clear_selected_valid_bit              = 1'b0;
      ctrl.finish_new_line_install               = 1'b0;
      ctrl.perform_write                         = 1'b0;
      ctrl.set_selected_dirty_bit                = 1'b0;
      if (reset) begin
         req_ready = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               req_ready = 1'b1;
               if (req_valid) begin
                  state_next = LOOKUP;
               end
            end
            LOOKUP: begin
               if (ctrl.valid_block_match) begin
                  resp_valid = 1'b1;
                  if (op_reg) begin
                     ctrl.perform_write          = 1'b1;
                     ctrl.set_selected_dirty_bit = 1'b1;
                  end
                  state_next = IDLE;
               end else begin
                  ctrl.miss_recovery_mode     = 1'b1;
                  ctrl.set_hmem_block_address = 1'b1;
                  ctrl.reset_counter          = 1'b1;
                  if (ctrl.valid_dirty_bit) begin
                     ctrl.use_victim_tag_for_hmem_block_address = 1'b1;
                     state_next = WRITEBACK;
                  end else begin
                     state_next = ALLOCATE;
                  end
               end
            end
            WRITEBACK: begin
               ctrl.miss_recovery_mode = 1'b1;
               hmem_req = 1'b1;
               hmem_we  = 1'b1;
               // Final word reloads the counter for the fill, so no decrement then.
               if (hmem_ack) begin
                  if (ctrl.counter_done) begin
                     ctrl.clear_selected_dirty_bit = 1'b1;
                     ctrl.clear_selected_valid_bit = 1'b1;
                     ctrl.set_hmem_block_address   = 1'b1;
                     ctrl.reset_counter            = 1'b1;
                     state_next = ALLOCATE;
                  end else begin
                     ctrl.decrement_counter = 1'b1;
                  end
               end
            end
            ALLOCATE: begin
               ctrl.miss_recovery_mode = 1'b1;
               hmem_req = 1'b1;
               if (hmem_ack) begin
                  ctrl.decrement_counter = 1'b1;
                  if (ctrl.counter_done) begin
                     ctrl.finish_new_line_install = 1'b1;
                     state_next = LOOKUP;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

`ifdef CACHE_CTRL_STATS_EN
   logic       replay_reg;
   logic [2:0] stat_event;

   always_ff @(posedge clk) begin
      if (reset) begin
         replay_reg <= 1'b0;
      end else if (state_reg == IDLE && req_valid) begin
         replay_reg <= 1'b0;
      end else if (state_reg == ALLOCATE && hmem_ack && ctrl.counter_done) begin
         replay_reg <= 1'b1;
      end
   end

   // Replayed lookups after a fill are not real hits and are excluded.
   assign stat_event[0] = (state_reg == LOOKUP) && ctrl.valid_block_match && !replay_reg;
   assign stat_event[1] = (state_reg == LOOKUP) && !ctrl.valid_block_match;
   assign stat_event[2] = (state_reg == WRITEBACK) && hmem_ack && ctrl.counter_done;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_stat
         logic [STAT_WIDTH-1:0] count_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               count_reg <= '0;
            end else if (stat_event[gi] && count_reg != {STAT_WIDTH{1'b1}}) begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   endgenerate

   assign hit_count       = g_stat[0].count_reg;
   assign miss_count      = g_stat[1].count_reg;
   assign writeback_count = g_stat[2].count_reg;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a small cache datapath model plus a transaction-level
// reference that predicts every controller output each cycle.
module tb_cache_controller;
   localparam int WORDS  = 4;
   localparam int STAT_W = 2;
   localparam int MAXV   = (1 << STAT_W) - 1;

   logic clk = 1'b0;
   logic reset, req_valid, req_op, req_ready, resp_valid, hmem_req, hmem_we, hmem_ack;
   cache_internal_if ctrl_if ();
`ifdef CACHE_CTRL_STATS_EN
   logic [STAT_W-1:0] hit_count, miss_count, writeback_count;
`endif

   cache_controller #(.STAT_WIDTH(STAT_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready), .resp_valid(resp_valid),
      .hmem_req(hmem_req), .hmem_we(hmem_we), .hmem_ack(hmem_ack),
      .ctrl(ctrl_if)
`ifdef CACHE_CTRL_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
   );

   always #5 clk = ~clk;

   logic [9:0] ctrl_vec;
   assign ctrl_vec = {ctrl_if.miss_recovery_mode, ctrl_if.set_hmem_block_address,
                      ctrl_if.reset_counter, ctrl_if.use_victim_tag_for_hmem_block_address,
                      ctrl_if.decrement_counter, ctrl_if.clear_selected_dirty_bit,
                      ctrl_if.clear_selected_valid_bit, ctrl_if.finish_new_line_install,
                      ctrl_if.perform_write, ctrl_if.set_selected_dirty_bit};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Datapath environment: 4 sets, 2-bit tags, WORDS-word lines, transfer counter.
   bit         env_valid [4];
   bit         env_dirty [4];
   logic [1:0] env_tag   [4];
   int         env_cnt;
   logic [1:0] addr_set, addr_tag;

   // Transaction-level reference state.
   bit started = 0;
   bit busy, look, replay, m_op;
   bit xq[$];
   int m_hit, m_miss, m_wb;
   int cyc, accept_cycle, resp_cycle;
   int dec_pulses, fin_pulses, resp_pulses, pw_pulses, rd_acks, wr_acks, hmem_cycles;

   function automatic int sat_inc(input int v);
      return (v >= MAXV) ? MAXV : v + 1;
   endfunction

   task automatic compare_cycle();
      bit e_rr, e_rv, e_hr, e_hw, e_mrm, e_sa, e_rc, e_uv, e_dc, e_cd, e_cv, e_fin, e_pw, e_sd;
      bit last;
      logic [13:0] act, exp;
      {e_rr, e_rv, e_hr, e_hw, e_mrm, e_sa, e_rc, e_uv, e_dc, e_cd, e_cv, e_fin, e_pw, e_sd} = '0;
`ifdef CACHE_CTRL_STATS_EN
      check("hit_count", 32'(hit_count), m_hit);
      check("miss_count", 32'(miss_count), m_miss);
      check("writeback_count", 32'(writeback_count), m_wb);
`endif
      if (reset) begin
         e_rr = 1; busy = 0; look = 0; replay = 0; xq.delete();
         m_hit = 0; m_miss = 0; m_wb = 0;
      end else if (!busy) begin
         e_rr = 1;
         if (req_valid) begin
            busy = 1; look = 1; replay = 0; m_op = req_op; accept_cycle = cyc;
         end
      end else if (look) begin
         if (replay) check("replay_hit", ctrl_if.valid_block_match, 1);
         if (ctrl_if.valid_block_match) begin
            e_rv = 1; e_pw = m_op; e_sd = m_op;
            if (!replay) m_hit = sat_inc(m_hit);
            busy = 0; look = 0;
         end else begin
            e_mrm = 1; e_sa = 1; e_rc = 1; e_uv = ctrl_if.valid_dirty_bit;
            if (ctrl_if.valid_dirty_bit) for (int i = 0; i < WORDS; i++) xq.push_back(1'b1);
            for (int i = 0; i < WORDS; i++) xq.push_back(1'b0);
            m_miss = sat_inc(m_miss);
            look = 0;
         end
      end else begin
         e_mrm = 1; e_hr = 1; e_hw = xq[0];
         if (hmem_ack) begin
            last = (xq.size() == 1) || (xq[1] != xq[0]);
            if (xq[0] && last) begin
               e_cd = 1; e_cv = 1; e_sa = 1; e_rc = 1; m_wb = sat_inc(m_wb);
            end else begin
               e_dc = 1;
            end
            if (!xq[0] && last) e_fin = 1;
            void'(xq.pop_front());
            if (xq.size() == 0) begin look = 1; replay = 1; end
         end
      end
      act = {req_ready, resp_valid, hmem_req, hmem_we, ctrl_vec};
      exp = {e_rr, e_rv, e_hr, e_hw, e_mrm, e_sa, e_rc, e_uv, e_dc, e_cd, e_cv, e_fin, e_pw, e_sd};
      check("outputs", 32'(act), 32'(exp));

      // Datapath reacts to the controller strobes at the coming edge.
      if (ctrl_if.reset_counter) env_cnt = WORDS - 1;
      else if (ctrl_if.decrement_counter) env_cnt = (env_cnt == 0) ? WORDS - 1 : env_cnt - 1;
      if (ctrl_if.set_selected_dirty_bit) env_dirty[addr_set] = 1;
      if (ctrl_if.clear_selected_dirty_bit) env_dirty[addr_set] = 0;
      if (ctrl_if.clear_selected_valid_bit) env_valid[addr_set] = 0;
      if (ctrl_if.finish_new_line_install) begin
         env_valid[addr_set] = 1; env_tag[addr_set] = addr_tag; env_dirty[addr_set] = 0;
      end

      if (resp_valid) begin resp_pulses++; resp_cycle = cyc; end
      if (ctrl_if.decrement_counter) dec_pulses++;
      if (ctrl_if.finish_new_line_install) fin_pulses++;
      if (ctrl_if.perform_write) pw_pulses++;
      if (hmem_req) hmem_cycles++;
      if (hmem_req && hmem_ack) begin
         if (hmem_we) wr_acks++;
         else rd_acks++;
      end
      cyc++;
   endtask

   always @(negedge clk) begin
      if (started) compare_cycle();
   end

   task automatic drive(input bit rv, input bit op, input bit ack, input bit rst);
      @(posedge clk);
      #1;
      reset = rst; req_valid = rv; req_op = op; hmem_ack = ack;
      ctrl_if.valid_block_match = env_valid[addr_set] && (env_tag[addr_set] == addr_tag);
      ctrl_if.valid_dirty_bit   = env_valid[addr_set] && env_dirty[addr_set];
      ctrl_if.counter_done      = (env_cnt == 0);
   endtask

   task automatic clear_counts();
      dec_pulses = 0; fin_pulses = 0; resp_pulses = 0; pw_pulses = 0;
      rd_acks = 0; wr_acks = 0; hmem_cycles = 0;
   endtask

   task automatic run_req(input logic [1:0] s, input logic [1:0] t, input bit op,
                          input bit rand_mode, input int ack_pct);
      int n;
      addr_set = s; addr_tag = t;
      clear_counts();
      drive(1, op, $urandom_range(99) < ack_pct, 0);
      n = 0;
      do begin
         drive(rand_mode && busy && $urandom_range(1) == 1, op, $urandom_range(99) < ack_pct,
               rand_mode && $urandom_range(199) == 0);
         n++;
      end while (busy && n < 400);
      check("req_done", 32'(busy), 0);
   endtask

   initial begin
      int n;
      reset = 1; req_valid = 0; req_op = 0; hmem_ack = 0;
      ctrl_if.valid_block_match = 0; ctrl_if.valid_dirty_bit = 0; ctrl_if.counter_done = 0;
      for (int i = 0; i < 4; i++) begin env_valid[i] = 0; env_dirty[i] = 0; env_tag[i] = 0; end
      env_cnt = WORDS - 1; addr_set = 0; addr_tag = 0;
      busy = 0; look = 0; replay = 0; m_op = 0; m_hit = 0; m_miss = 0; m_wb = 0; cyc = 0;
      accept_cycle = 0; resp_cycle = 0;
      clear_counts();
      drive(0, 0, 0, 1);
      started = 1;
      drive(0, 0, 0, 1);
      drive(0, 0, 1, 0);
      #1;
      check("reset_req_ready", 32'(req_ready), 1);
      check("reset_hmem_req", 32'(hmem_req), 0);
      check("reset_ctrl", 32'(ctrl_vec), 0);

      // Clean read miss on an empty set.
      run_req(2'd0, 2'd1, 1'b0, 1'b0, 75);
      check("clean_decrements", dec_pulses, 4);
      check("clean_installs", fin_pulses, 1);
      check("clean_fill_acks", rd_acks, 4);
      check("clean_wb_acks", wr_acks, 0);
      check("clean_resp", resp_pulses, 1);
`ifdef CACHE_CTRL_STATS_EN
      check("clean_stat_hit", 32'(hit_count), 0);
      check("clean_stat_miss", 32'(miss_count), 1);
`endif

      // Read hit: response one cycle after acceptance, no memory traffic.
      run_req(2'd0, 2'd1, 1'b0, 1'b0, 75);
      check("hit_latency", resp_cycle - accept_cycle, 1);
      check("hit_no_hmem", hmem_cycles, 0);

      // Write hit marks the line dirty.
      run_req(2'd0, 2'd1, 1'b1, 1'b0, 75);
      check("write_hit_pw", pw_pulses, 1);
      check("write_hit_dirty", 32'(env_dirty[0]), 1);

      // Dirty miss: write-back then fill, line replaced.
      run_req(2'd0, 2'd2, 1'b0, 1'b0, 75);
      check("dirty_wb_acks", wr_acks, 4);
      check("dirty_fill_acks", rd_acks, 4);
      check("dirty_decrements", dec_pulses, 7);
      check("dirty_resp", resp_pulses, 1);
      check("dirty_new_tag", 32'(env_tag[0]), 2);
      check("dirty_clean_after", 32'(env_dirty[0]), 0);
`ifdef CACHE_CTRL_STATS_EN
      check("dirty_stat_hit", 32'(hit_count), 2);
      check("dirty_stat_miss", 32'(miss_count), 2);
      check("dirty_stat_wb", 32'(writeback_count), 1);
`endif

      // Reset two words into a fill.
      addr_set = 2'd1; addr_tag = 2'd0;
      clear_counts();
      drive(1, 0, 0, 0);
      n = 0;
      do begin
         drive(0, 0, 1, 0);
         @(negedge clk);
         #1;
         n++;
      end while (rd_acks < 2 && n < 50);
      check("midfill_acks", rd_acks, 2);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      #1;
      check("midfill_req_ready", 32'(req_ready), 1);
      check("midfill_hmem_req", 32'(hmem_req), 0);
      check("midfill_ctrl", 32'(ctrl_vec), 0);
      check("midfill_line_invalid", 32'(env_valid[1]), 0);

      // Random traffic with stray acks, ignored requests and occasional resets.
      for (int i = 0; i < 250; i++) begin
         run_req(2'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(1)), 1'b1, 60);
      end
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end
endmodule
